aes512_decryption_seq: RTL and testbench
========================================

Name: aes512_decryption_seq

Overview:
- Inverse of the 512-bit four-lane AES-128 encryption block.
- Accepts a 512-bit ciphertext and a 512-bit key over a valid/ready handshake.
- Decrypts the four 128-bit lanes by time-multiplexing one combinational aes128_decryption core, then re-interleaves the recovered bytes into the original 512-bit plaintext order.
- Sits on the receive side of the 512-bit AES datapath.

Parameters:
- None. Widths are fixed: 512-bit block, 4 lanes × 128 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext and key are valid.
- in_ready  output  1  block can accept a new ciphertext.
- cipher_data  input  512  ciphertext [0:511]; lane k = bits [128k +: 128].
- cipher_key  input  512  key [0:511]; lane k key = bits [128k +: 128].
- out_valid  output  1  decrypted_data is valid.
- out_ready  input  1  downstream accepts decrypted_data.
- decrypted_data  output  512  recovered plaintext [0:511].

Behaviour:
- Reset (async, immediate):
  - state = IDLE, lane counter = 0.
  - out_valid = 0.
  - decrypted_data = 0; internal cipher, key and lane registers = 0.
  - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after release.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - in_ready = 1.
    - At an edge with in_valid = 1: capture cipher_data and cipher_key, lane = 0, go to RUN.
  - RUN:
    - in_ready = 0.
    - The core receives cipher lane [lane] and key lane [lane].
    - Each edge registers the core output into plain lane [lane] and increments lane.
    - The edge that captures lane 3 moves the FSM to DONE.
  - DONE:
    - out_valid = 1, in_ready = 0.
    - At an edge with out_ready = 1: go to IDLE and drop out_valid.
- Byte re-interleave (bytes are MSB-first, byte j = bits [8j +: 8]):
  - decrypted_data byte (4i + k) = plain lane k byte i, for i = 0..15 and k = 0..3.
  - decrypted_data is updated only on entry to DONE.
- Latency and throughput:
  - Accept at edge E0; lanes captured at E1..E4; out_valid is high after E4.
  - With in_valid and out_ready held high, blocks are accepted every 6 cycles.
- Handshake rules:
  - No overlap: a new block is never accepted while in RUN or DONE.
  - in_valid is ignored outside IDLE.
  - decrypted_data and out_valid hold stable while out_valid = 1 and out_ready = 0, for any number of cycles.
- Captured inputs: after acceptance, changes on cipher_data and cipher_key have no effect on the block in flight.
- Reset mid-operation: rst in RUN or DONE discards the block; outputs return to their reset values.
- Decryption core: exactly one aes128_decryption instance in serial mode. It is the standard FIPS-197 inverse cipher with a 128-bit key.

Optional Feature:
- Macro: AES512_DEC_PARALLEL_EN.
- Defined:
  - Four aes128_decryption instances decode all lanes at once.
  - RUN lasts one cycle: accept at E0, out_valid high after E1.
  - Back-to-back blocks are accepted every 3 cycles.
  - Ports, handshake rules and byte mapping are unchanged.
- Undefined: the serial single-core behaviour above.

Test Plan:
- FIPS-197 vector:
  - Stimulus: all four key lanes = 000102030405060708090a0b0c0d0e0f; all four cipher lanes = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: decrypted_data = 00000000111111112222222233333333 … ffffffff, i.e. each plaintext byte repeated 4×.
  - Timing: out_valid rises 4 edges after acceptance (1 with AES512_DEC_PARALLEL_EN).
- Round trip:
  - Stimulus: random 512-bit data and key; run through the encryption block, then feed its output and the same key to this block.
  - Response: decrypted_data equals the original data, with 4 distinct lane keys.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises; toggle in_valid and cipher_data during that time.
  - Response: decrypted_data stable, out_valid stays 1, in_ready stays 0, no new block accepted.
- Throughput:
  - Stimulus: in_valid and out_ready held 1 for 3 blocks.
  - Response: acceptances exactly 6 cycles apart (3 in parallel mode); each result correct and in order.
- Reset mid-RUN:
  - Stimulus: assert rst two edges after acceptance.
  - Response: out_valid = 0 and decrypted_data = 0 immediately; in_ready = 1 after release; the next FIPS-197 block decodes correctly.
- Input change after accept:
  - Stimulus: change cipher_key on the cycle after acceptance.
  - Response: result still matches the originally captured key.

Source files
------------

// File: rtl/aes512_decryption_seq.sv
// Four-lane AES-128 decryptor: 512-bit ciphertext/key in, lanes decoded on one shared core, bytes re-interleaved.
// Optional macro AES512_DEC_PARALLEL_EN instantiates four cores and decodes all lanes in a single RUN cycle.

module aes128_decryption (
  input  logic [0:127] cipher,
  input  logic [0:127] key,
  output logic [0:127] plain
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t, r;
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b, s;
    b = gf_inv(a);
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
    return gf_inv(b ^ 8'h05);
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      o[32*c + 8  +: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      o[32*c + 16 +: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      o[32*c + 24 +: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_cipher(input logic [0:127] ct, input logic [0:127] k);
    logic [0:1407] rk;
    logic [0:31]   t;
    logic [7:0]    rc;
    logic [0:127]  s, u;
    rk[0:127] = k;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = rk[32*(i-1) +: 32];
      if (i % 4 == 0) begin
        t  = {sbox(t[8:15]) ^ rc, sbox(t[16:23]), sbox(t[24:31]), sbox(t[0:7])};
        rc = xtime(rc);
      end
      rk[32*i +: 32] = rk[32*(i-4) +: 32] ^ t;
    end
    s = ct ^ rk[1280 +: 128];
    // InvShiftRows and InvSubBytes commute, so both are folded into one byte gather.
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          u[8*(4*c + row) +: 8] = inv_sbox(s[8*(4*((c - row + 4) % 4) + row) +: 8]);
      s = u ^ rk[128*r +: 128];
      if (r != 0) s = inv_mix(s);
    end
    return s;
  endfunction

  assign plain = inv_cipher(cipher, key);

endmodule

module aes512_decryption_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:511] cipher_data,
  input  logic [0:511] cipher_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:511] decrypted_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [0:511] cipher_q, key_q, plain_nxt;
  logic         lanes_done;

  // Output byte 4i+k comes from byte i of lane k.
  function automatic logic [0:511] interleave(input logic [0:511] p);
    logic [0:511] r;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++)
        r[8*(4*i + k) +: 8] = p[128*k + 8*i +: 8];
    return r;
  endfunction

`ifdef AES512_DEC_PARALLEL_EN
  for (genvar g = 0; g < 4; g++) begin : g_core
    aes128_decryption u_core (
      .cipher (cipher_q[128*g +: 128]),
      .key    (key_q[128*g +: 128]),
      .plain  (plain_nxt[128*g +: 128])
    );
  end
  assign lanes_done = 1'b1;
`else
  logic [1:0]   lane;
  logic [0:511] plain_q;
  logic [0:127] core_plain;

  aes128_decryption u_core (
    .cipher (cipher_q[128*lane +: 128]),
    .key    (key_q[128*lane +: 128]),
    .plain  (core_plain)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives plain_nxt and no latch is inferred.
    plain_nxt = plain_q;
    plain_nxt[128*lane +: 128] = core_plain;
  end

  assign lanes_done = (lane == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane    <= 2'd0;
      plain_q <= '0;
    end else if (state == IDLE && in_valid) begin
      lane <= 2'd0;
    end else if (state == RUN) begin
      lane    <= lane + 2'd1;
      plain_q <= plain_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (lanes_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide datapath registers are reset as well, so an aborted block leaves nothing behind.
      state          <= IDLE;
      cipher_q       <= '0;
      key_q          <= '0;
      decrypted_data <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        cipher_q <= cipher_data;
        key_q    <= cipher_key;
      end
      if (state == RUN && lanes_done) decrypted_data <= interleave(plain_nxt);
    end
  end

endmodule

// File: tb/tb_aes512_decryption_seq.sv
// Scoreboard bench for aes512_decryption_seq: an AES-128 encryption model produces ciphertexts whose plaintexts are expected back.
module tb_aes512_decryption_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [0:511] cipher_data, cipher_key, decrypted_data;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;

  logic [7:0]   sbox [0:255];
  logic [0:511] exp_q [$];
  int           accept_cyc [$];

`ifdef AES512_DEC_PARALLEL_EN
  localparam int LATENCY = 1;
  localparam int PERIOD  = 3;
`else
  localparam int LATENCY = 4;
  localparam int PERIOD  = 6;
`endif

  localparam logic [0:511] FIPS_KEY = {4{128'h000102030405060708090a0b0c0d0e0f}};
  localparam logic [0:511] FIPS_CT  = {4{128'h69c4e0d86a7b0430d8cdb78070b4c55a}};
  localparam logic [0:511] FIPS_PT  = 512'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888_99999999_aaaaaaaa_bbbbbbbb_cccccccc_dddddddd_eeeeeeee_ffffffff;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  aes512_decryption_seq dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cipher_data    (cipher_data),
    .cipher_key     (cipher_key),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .decrypted_data (decrypted_data)
  );

  task automatic check(input string name, input logic [0:511] act, input logic [0:511] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box from the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] aes_enc(input logic [0:127] pt, input logic [0:127] key);
    logic [7:0] w [0:175];
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] tmp [0:3];
    logic [7:0] rc;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
      if (i % 16 == 0) begin
        tmp[0] = sbox[w[i-3]] ^ rc;
        tmp[1] = sbox[w[i-2]];
        tmp[2] = sbox[w[i-1]];
        tmp[3] = sbox[w[i-4]];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
    end
    for (int j = 0; j < 16; j++) s[j] = pt[8*j +: 8] ^ w[j];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c + row] = sbox[s[4*((c + row) % 4) + row]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c + row] = t[4*c + row];
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[16*r + j];
    end
    for (int j = 0; j < 16; j++) o[8*j +: 8] = s[j];
    return o;
  endfunction

  // Splits data into lanes (lane k byte i = data byte 4i+k) and encrypts each with its own key lane.
  function automatic logic [0:511] encrypt_block(input logic [0:511] d, input logic [0:511] k);
    logic [0:511] c;
    logic [0:127] lane_pt;
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < 16; i++) lane_pt[8*i +: 8] = d[8*(4*i + kk) +: 8];
      c[128*kk +: 128] = aes_enc(lane_pt, k[128*kk +: 128]);
    end
    return c;
  endfunction

  function automatic logic [0:511] rand512();
    logic [0:511] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge with the inputs scrambled.
  task automatic send(input logic [0:511] c, input logic [0:511] k, input logic [0:511] exp, input bit keep_valid);
    int waited = 0;
    in_valid    = 1'b1;
    cipher_data = c;
    cipher_key  = k;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(exp);
    accept_cyc.push_back(cycle);
    @(posedge clk); #1;
    in_valid    = keep_valid;
    cipher_data = rand512();
    cipher_key  = rand512();
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (edges > 50) begin
        check("out_valid_timeout", out_valid, 1);
        break;
      end
      @(posedge clk);
      edges++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
        else check("result", decrypted_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [0:511] d, k, snap;
    int lat;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cipher_data = '0; cipher_key = '0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_data", decrypted_data, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0);
    wait_out(lat);
    check("fips_latency", lat, LATENCY);
    drain();

    for (int n = 0; n < 6; n++) begin
      d = rand512();
      k = rand512();
      send(encrypt_block(d, k), k, d, 1'b0);
    end
    drain();

    accept_cyc.delete();
    for (int n = 0; n < 3; n++) begin
      d = rand512();
      k = rand512();
      send(encrypt_block(d, k), k, d, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    for (int n = 1; n < accept_cyc.size(); n++)
      check("throughput_spacing", accept_cyc[n] - accept_cyc[n-1], PERIOD);
    check("throughput_count", accept_cyc.size(), 3);

    out_ready = 1'b0;
    d = rand512();
    k = rand512();
    send(encrypt_block(d, k), k, d, 1'b0);
    wait_out(lat);
    snap = decrypted_data;
    for (int n = 0; n < 10; n++) begin
      in_valid    = 1'(($urandom & 1));
      cipher_data = rand512();
      @(negedge clk);
      check("bp_data_stable", decrypted_data, snap);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    check("bp_no_extra_block", out_valid, 0);
    @(posedge clk); #1;

    send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrun_out_valid", out_valid, 0);
    check("midrun_data", decrypted_data, '0);
    check("midrun_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_midrun", in_ready, 1);
    @(posedge clk); #1;
    send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    check("final_idle", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
